// File: rtl/sqrt_fixup_fifo.sv
// Converts ceiling-root results from the 8-bit square-root unit into floor root plus
// remainder. It also checks each result for consistency, counts exact and inexact
// results, and buffers them in a small credit-protected FIFO.
module sqrt_fixup_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_radicand,
  input  logic [7:0]                in_root,
  input  logic                      in_exact,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_floor,
  output logic [7:0]                out_rem,
  output logic                      out_exact,
  output logic                      err_flag,
  output logic [CNT_W-1:0]          exact_cnt,
  output logic [CNT_W-1:0]          inexact_cnt,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Valid is never withdrawn by this block, and ready never depends on valid.

  logic             s1_valid, s1_exact;
  logic [7:0]       s1_rad, s1_root, s1_floor;
  logic             s2_valid, s2_exact;
  logic [7:0]       s2_floor, s2_rem;

  logic [7:0]       floor_mem [DEPTH];
  logic [7:0]       rem_mem   [DEPTH];
  logic             exact_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  logic             accept, push, pop;
  logic [LW:0]      credit;
  logic [7:0]       root_m1;
  logic [15:0]      rad16, sq_root, sq_root_m1, sq_floor, rem_full;
  logic             err_check;

  // Credits cover everything in flight, so a pipeline entry always finds a FIFO slot.
  assign credit    = {1'b0, level} + (LW+1)'(s1_valid) + (LW+1)'(s2_valid);
  assign in_ready  = credit < (LW+1)'(DEPTH);
  assign accept    = in_valid & in_ready;
  assign push      = s2_valid;
  assign out_valid = level != '0;
  assign pop       = out_valid & out_ready;

  assign out_floor = floor_mem[rd_ptr];
  assign out_rem   = rem_mem[rd_ptr];
  assign out_exact = exact_mem[rd_ptr];

  always_comb begin
    root_m1    = s1_root - 8'd1;
    rad16      = {8'd0, s1_rad};
    sq_root    = {8'd0, s1_root} * {8'd0, s1_root};
    sq_root_m1 = {8'd0, root_m1} * {8'd0, root_m1};
    sq_floor   = {8'd0, s1_floor} * {8'd0, s1_floor};
    rem_full   = rad16 - sq_floor;
    if (s1_exact)
      err_check = sq_root != rad16;
    else
      err_check = (s1_root == 8'd0) || (sq_root <= rad16) || (sq_root_m1 > rad16);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_exact <= 1'b0;
      s1_rad   <= '0;
      s1_root  <= '0;
      s1_floor <= '0;
      s2_valid <= 1'b0;
      s2_exact <= 1'b0;
      s2_floor <= '0;
      s2_rem   <= '0;
      err_flag <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_rad   <= in_radicand;
        s1_root  <= in_root;
        s1_exact <= in_exact;
        s1_floor <= in_exact ? in_root : in_root - 8'd1;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_floor <= s1_floor;
        s2_rem   <= rem_full[7:0];
        s2_exact <= s1_exact & ~err_check;
        if (err_check) err_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        floor_mem[i] <= '0;
        rem_mem[i]   <= '0;
        exact_mem[i] <= 1'b0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      exact_cnt   <= '0;
      inexact_cnt <= '0;
    end else begin
      if (push) begin
        floor_mem[wr_ptr] <= s2_floor;
        rem_mem[wr_ptr]   <= s2_rem;
        exact_mem[wr_ptr] <= s2_exact;
        wr_ptr            <= wr_ptr + AW'(1);
        if (s2_exact) begin
          if (exact_cnt != '1) exact_cnt <= exact_cnt + CNT_W'(1);
        end else begin
          if (inexact_cnt != '1) inexact_cnt <= inexact_cnt + CNT_W'(1);
        end
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: tb/tb_sqrt_fixup_fifo.sv
// Directed bench for sqrt_fixup_fifo: latency, floor/remainder conversion, backpressure,
// error flag, reset mid-flight and counter saturation on a CNT_W=2 instance.
module tb_sqrt_fixup_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_radicand = '0;
  logic [7:0] in_root = '0;
  logic       in_exact = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_floor, out_rem;
  logic       out_exact, err_flag;
  logic [7:0] exact_cnt, inexact_cnt;
  logic [2:0] level;

  logic       in_ready2, out_valid2, out_exact2, err_flag2;
  logic       out_ready2 = 1'b1;
  logic [7:0] out_floor2, out_rem2;
  logic [1:0] exact_cnt2, inexact_cnt2;
  logic [2:0] level2;

  int total = 0;
  int bad = 0;

  sqrt_fixup_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_radicand(in_radicand), .in_root(in_root), .in_exact(in_exact),
    .out_valid(out_valid), .out_ready(out_ready), .out_floor(out_floor),
    .out_rem(out_rem), .out_exact(out_exact), .err_flag(err_flag),
    .exact_cnt(exact_cnt), .inexact_cnt(inexact_cnt), .level(level)
  );

  sqrt_fixup_fifo #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_radicand(in_radicand), .in_root(in_root), .in_exact(in_exact),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_floor(out_floor2),
    .out_rem(out_rem2), .out_exact(out_exact2), .err_flag(err_flag2),
    .exact_cnt(exact_cnt2), .inexact_cnt(inexact_cnt2), .level(level2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks; all start and end on a falling edge
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] rad, input logic [7:0] root, input logic ex);
    int waited;
    in_radicand = rad;
    in_root     = root;
    in_exact    = ex;
    in_valid    = 1'b1;
    waited      = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_head(output logic [7:0] f, output logic [7:0] r, output logic e,
                          output logic ok);
    int waited;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = out_valid;
    f  = out_floor;
    r  = out_rem;
    e  = out_exact;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if ({out_floor, out_rem, out_exact} !== 17'd0) begin bad++; $display("FAIL reset_head: got %0h/%0h/%0b want 0/0/0", out_floor, out_rem, out_exact); end
    total++; if ({err_flag, exact_cnt, inexact_cnt} !== 17'd0) begin bad++; $display("FAIL reset_stats: err=%0b ex=%0d inex=%0d want 0", err_flag, exact_cnt, inexact_cnt); end
    do_reset();
  endtask

  task automatic test_single_exact();
    do_reset();
    out_ready = 1'b1;
    push(8'd16, 8'd4, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_after_e0: out_valid=%0b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_after_e1: out_valid=%0b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_after_e2: out_valid=%0b want 1", out_valid); end
    total++; if ({out_floor, out_rem, out_exact} !== {8'd4, 8'd0, 1'b1}) begin bad++; $display("FAIL single_data: got %0d/%0d/%0b want 4/0/1", out_floor, out_rem, out_exact); end
    total++; if (exact_cnt !== 8'd1 || inexact_cnt !== 8'd0) begin bad++; $display("FAIL single_cnt: ex=%0d inex=%0d want 1/0", exact_cnt, inexact_cnt); end
    @(negedge clk);
    total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_popped: level=%0d valid=%0b want 0/0", level, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_inexact_boundary();
    logic [7:0] f, r;
    logic e, ok;
    logic [7:0] rad_v [3] = '{8'd20, 8'd255, 8'd0};
    logic [7:0] root_v[3] = '{8'd5, 8'd16, 8'd0};
    logic       ex_v  [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] fl_x  [3] = '{8'd4, 8'd15, 8'd0};
    logic [7:0] rem_x [3] = '{8'd4, 8'd30, 8'd0};
    do_reset();
    for (int i = 0; i < 3; i++) push(rad_v[i], root_v[i], ex_v[i]);
    for (int i = 0; i < 3; i++) begin
      get_head(f, r, e, ok);
      total++;
      if (!ok || f !== fl_x[i] || r !== rem_x[i] || e !== ex_v[i]) begin
        bad++;
        $display("FAIL inexact_%0d: got v=%0b %0d/%0d/%0b want 1 %0d/%0d/%0b", i, ok, f, r, e, fl_x[i], rem_x[i], ex_v[i]);
      end
    end
    total++; if (exact_cnt !== 8'd1 || inexact_cnt !== 8'd2) begin bad++; $display("FAIL inexact_cnt: ex=%0d inex=%0d want 1/2", exact_cnt, inexact_cnt); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL inexact_err: got %0b want 0", err_flag); end
  endtask

  task automatic test_backpressure();
    logic [7:0] f, r;
    logic e, ok, acc;
    int k, accepts;
    do_reset();
    k = 1;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      in_radicand = 8'(k * k);
      in_root     = 8'(k);
      in_exact    = 1'b1;
      in_valid    = 1'b1;
      acc         = in_ready;
      @(negedge clk);
      if (acc) begin k++; accepts++; end
    end
    in_valid = 1'b0;
    total++; if (accepts != 4) begin bad++; $display("FAIL bp_accepts: got %0d want 4", accepts); end
    total++; if (in_ready !== 1'b0 || level !== 3'd4) begin bad++; $display("FAIL bp_full: in_ready=%0b level=%0d want 0/4", in_ready, level); end
    total++; if (out_floor !== 8'd1) begin bad++; $display("FAIL bp_head_stable: got %0d want 1", out_floor); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || level !== 3'd3) begin bad++; $display("FAIL bp_after_pop: in_ready=%0b level=%0d want 1/3", in_ready, level); end
    for (int i = 2; i <= 4; i++) begin
      get_head(f, r, e, ok);
      total++;
      if (!ok || f !== 8'(i) || r !== 8'd0 || e !== 1'b1) begin
        bad++;
        $display("FAIL bp_order_%0d: got v=%0b %0d/%0d/%0b want 1 %0d/0/1", i, ok, f, r, e, i);
      end
    end
  endtask

  task automatic test_error();
    logic [7:0] f, r;
    logic e, ok;
    do_reset();
    push(8'd20, 8'd4, 1'b1);
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL err_after_e0: got %0b want 0", err_flag); end
    @(negedge clk);
    total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL err_after_e1: got %0b want 1", err_flag); end
    get_head(f, r, e, ok);
    total++; if (!ok || f !== 8'd4 || r !== 8'd4 || e !== 1'b0) begin bad++; $display("FAIL err_entry: got v=%0b %0d/%0d/%0b want 1 4/4/0", ok, f, r, e); end
    total++; if (inexact_cnt !== 8'd1 || exact_cnt !== 8'd0) begin bad++; $display("FAIL err_cnt: ex=%0d inex=%0d want 0/1", exact_cnt, inexact_cnt); end
    push(8'd16, 8'd4, 1'b1);
    get_head(f, r, e, ok);
    total++; if (!ok || f !== 8'd4 || r !== 8'd0 || e !== 1'b1) begin bad++; $display("FAIL err_next: got v=%0b %0d/%0d/%0b want 1 4/0/1", ok, f, r, e); end
    total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", err_flag); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    push(8'd20, 8'd4, 1'b1);
    push(8'd9, 8'd3, 1'b1);
    push(8'd10, 8'd4, 1'b0);
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL mid_reset_fifo: valid=%0b level=%0d want 0/0", out_valid, level); end
    total++; if ({err_flag, exact_cnt, inexact_cnt} !== 17'd0) begin bad++; $display("FAIL mid_reset_stats: err=%0b ex=%0d inex=%0d want 0", err_flag, exact_cnt, inexact_cnt); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d: out_valid=%0b want 0", c, out_valid); end
    end
    total++; if (exact_cnt !== 8'd0 || inexact_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt: ex=%0d inex=%0d want 0/0", exact_cnt, inexact_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'd4, 8'd2, 1'b1);
    repeat (6) @(negedge clk);
    total++; if (exact_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2: got %0d want 3", exact_cnt2); end
    total++; if (inexact_cnt2 !== 2'd0) begin bad++; $display("FAIL sat_inexact2: got %0d want 0", inexact_cnt2); end
    total++; if (exact_cnt !== 8'd5) begin bad++; $display("FAIL sat_cnt8: got %0d want 5", exact_cnt); end
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_exact();
    test_inexact_boundary();
    test_backpressure();
    test_error();
    test_reset_midflight();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
